// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction encoder.
// Packs decoded fields plus a full 32-bit immediate into an R/I/S/B/U/J word,
// and expands the LI pseudo-op into LUI+ADDI, which needs up to two words.
// A one-entry output register sits behind valid/ready handshakes on both sides.
// Optional feature: define RANGE_CHECK_EN to flag immediates that cannot be
// represented in the selected format; otherwise o_RangeErr is tied low.
module instr_encoder (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic [2:0]  i_Format,
  input  logic [6:0]  i_Opcode,
  input  logic [4:0]  i_Rd,
  input  logic [4:0]  i_Rs1,
  input  logic [4:0]  i_Rs2,
  input  logic [2:0]  i_Funct3,
  input  logic [6:0]  i_Funct7,
  input  logic [31:0] i_Imm,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [31:0] o_Instruction,
  output logic        o_Last,
  output logic        o_RangeErr
);

  localparam int WORD_SIZE = 32;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_LI = 3'd6;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [WORD_SIZE-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {EMPTY, FULL, LI_HI} state_t;

  state_t               state;
  logic                 accept;
  logic [WORD_SIZE-1:0] li_sum;
  logic [19:0]          hi20;
  logic [11:0]          lo12;
  logic [WORD_SIZE-1:0] first_word;
  logic [WORD_SIZE-1:0] second_word;
  logic [WORD_SIZE-1:0] pending_word;
  logic                 first_last;
  logic                 two_word;
  logic                 range_err;

  // Input is taken when empty, or when the held word leaves this same cycle.
  assign o_Ready = (state == EMPTY) || ((state == FULL) && i_Ready);
  assign accept  = i_Valid && o_Ready;

  // LI split: rounding by 0x800 compensates for ADDI sign-extending lo12.
  assign li_sum = i_Imm + 32'h0000_0800;
  assign hi20   = li_sum[31:12];
  assign lo12   = i_Imm[11:0];

  // Pack the request fields into the first word and, for a 2-word LI, the ADDI.
  always_comb begin
    first_word  = NOP_WORD;
    second_word = '0;
    first_last  = 1'b1;
    two_word    = 1'b0;
    case (i_Format)
      FMT_R: first_word = {i_Funct7, i_Rs2, i_Rs1, i_Funct3, i_Rd, i_Opcode};
      FMT_I: first_word = {i_Imm[11:0], i_Rs1, i_Funct3, i_Rd, i_Opcode};
      FMT_S: first_word = {i_Imm[11:5], i_Rs2, i_Rs1, i_Funct3, i_Imm[4:0], i_Opcode};
      FMT_B: first_word = {i_Imm[12], i_Imm[10:5], i_Rs2, i_Rs1, i_Funct3,
                           i_Imm[4:1], i_Imm[11], i_Opcode};
      FMT_U: first_word = {i_Imm[31:12], i_Rd, i_Opcode};
      FMT_J: first_word = {i_Imm[20], i_Imm[10:1], i_Imm[11], i_Imm[19:12],
                           i_Rd, i_Opcode};
      FMT_LI: begin
        if (hi20 == 20'd0) begin
          first_word = {lo12, 5'd0, 3'd0, i_Rd, OP_IMM};
        end else if (lo12 == 12'd0) begin
          first_word = {hi20, i_Rd, OP_LUI};
        end else begin
          first_word  = {hi20, i_Rd, OP_LUI};
          second_word = {lo12, i_Rd, 3'd0, i_Rd, OP_IMM};
          first_last  = 1'b0;
          two_word    = 1'b1;
        end
      end
      default: first_word = NOP_WORD;
    endcase
  end

`ifdef RANGE_CHECK_EN
  logic signed [WORD_SIZE-1:0] simm;
  assign simm = $signed(i_Imm);

  // Flag immediates whose significant bits would be dropped by the packing.
  always_comb begin
    range_err = 1'b0;
    case (i_Format)
      FMT_I, FMT_S: range_err = (simm < -2048) || (simm > 2047);
      FMT_B:        range_err = (simm < -4096) || (simm > 4094) || i_Imm[0];
      FMT_J:        range_err = (simm < -1048576) || (simm > 1048574) || i_Imm[0];
      FMT_U:        range_err = (i_Imm[11:0] != 12'd0);
      FMT_R, FMT_LI: range_err = 1'b0;
      default:      range_err = 1'b1;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  // Output register and control state; the ADDI half of LI waits in pending_word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= EMPTY;
      o_Valid       <= 1'b0;
      o_Instruction <= '0;
      o_Last        <= 1'b0;
      o_RangeErr    <= 1'b0;
      pending_word  <= '0;
    end else begin
      case (state)
        EMPTY, FULL: begin
          if (accept) begin
            o_Valid       <= 1'b1;
            o_Instruction <= first_word;
            o_Last        <= first_last;
            o_RangeErr    <= range_err;
            pending_word  <= second_word;
            state         <= two_word ? LI_HI : FULL;
          end else if ((state == FULL) && i_Ready) begin
            o_Valid <= 1'b0;
            state   <= EMPTY;
          end
        end
        LI_HI: begin
          if (i_Ready) begin
            o_Instruction <= pending_word;
            o_Last        <= 1'b1;
            state         <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed plus randomized checks of instr_encoder against a
// queue-based reference model of the words each request should produce.
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [31:0] word;
    logic        last;
    logic        rerr;
  } exp_t;

  logic        i_clk, i_rst, i_Valid, o_Ready, i_Ready;
  logic [2:0]  i_Format, i_Funct3;
  logic [6:0]  i_Opcode, i_Funct7;
  logic [4:0]  i_Rd, i_Rs1, i_Rs2;
  logic [31:0] i_Imm, o_Instruction;
  logic        o_Valid, o_Last, o_RangeErr;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic exp_range_2048;

  instr_encoder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Format(i_Format), .i_Opcode(i_Opcode), .i_Rd(i_Rd), .i_Rs1(i_Rs1),
    .i_Rs2(i_Rs2), .i_Funct3(i_Funct3), .i_Funct7(i_Funct7), .i_Imm(i_Imm),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Instruction(o_Instruction),
    .o_Last(o_Last), .o_RangeErr(o_RangeErr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic req_t mkReq(input logic [2:0] fmt, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  // Bit field of the immediate extracted with plain arithmetic.
  function automatic longint fld(input logic [31:0] x, input int hi, input int lo);
    longint v;
    v = longint'(x);
    return (v / (longint'(1) << lo)) % (longint'(1) << (hi - lo + 1));
  endfunction

  function automatic logic [31:0] encodeRef(input req_t r);
    longint w;
    longint rd, rs1, rs2, f3, f7, op;
    rd = r.rd; rs1 = r.rs1; rs2 = r.rs2; f3 = r.f3; f7 = r.f7; op = r.op;
    case (r.fmt)
      3'd0: w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
      3'd1: w = fld(r.imm, 11, 0) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
      3'd2: w = fld(r.imm, 11, 5) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12
                + fld(r.imm, 4, 0) * 2**7 + op;
      3'd3: w = fld(r.imm, 12, 12) * 2**31 + fld(r.imm, 10, 5) * 2**25 + rs2 * 2**20
                + rs1 * 2**15 + f3 * 2**12 + fld(r.imm, 4, 1) * 2**8
                + fld(r.imm, 11, 11) * 2**7 + op;
      3'd4: w = fld(r.imm, 31, 12) * 2**12 + rd * 2**7 + op;
      3'd5: w = fld(r.imm, 20, 20) * 2**31 + fld(r.imm, 10, 1) * 2**21
                + fld(r.imm, 11, 11) * 2**20 + fld(r.imm, 19, 12) * 2**12 + rd * 2**7 + op;
      default: w = 19;
    endcase
    return w[31:0];
  endfunction

  function automatic logic rangeRef(input req_t r);
`ifdef RANGE_CHECK_EN
    longint s;
    s = longint'($signed(r.imm));
    case (r.fmt)
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3: return (s < -4096) || (s > 4094) || (s % 2 != 0);
      3'd5: return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      3'd4: return fld(r.imm, 11, 0) != 0;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (r.fmt == 3'd7) && 1'b0;
`endif
  endfunction

  // Queue the words a request should produce, in emission order.
  task automatic modelPush(input req_t r);
    longint u, hi, lo, rd;
    exp_t e;
    if (r.fmt == 3'd6) begin
      u  = longint'(r.imm);
      hi = ((u + 2048) % 64'h1_0000_0000) / 4096;
      lo = u % 4096;
      rd = r.rd;
      if (hi == 0) begin
        e.word = 32'(lo * 2**20 + rd * 2**7 + 19); e.last = 1'b1; e.rerr = 1'b0;
        exp_q.push_back(e);
      end else begin
        e.word = 32'(hi * 2**12 + rd * 2**7 + 55); e.last = (lo == 0); e.rerr = 1'b0;
        exp_q.push_back(e);
        if (lo != 0) begin
          e.word = 32'(lo * 2**20 + rd * 2**15 + rd * 2**7 + 19); e.last = 1'b1;
          exp_q.push_back(e);
        end
      end
    end else begin
      e.word = encodeRef(r); e.last = 1'b1; e.rerr = rangeRef(r);
      exp_q.push_back(e);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model, advance a clock.
  task automatic applyStimulus(input logic v, input req_t r, input logic rdy);
    logic exp_ready;
    i_Valid = v; i_Format = r.fmt; i_Opcode = r.op; i_Rd = r.rd; i_Rs1 = r.rs1;
    i_Rs2 = r.rs2; i_Funct3 = r.f3; i_Funct7 = r.f7; i_Imm = r.imm; i_Ready = rdy;
    #1;
    exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && rdy);
    checkOutput("valid", 32'(o_Valid), 32'(exp_q.size() != 0));
    checkOutput("ready", 32'(o_Ready), 32'(exp_ready));
    if (exp_q.size() != 0) begin
      checkOutput("word", o_Instruction, exp_q[0].word);
      checkOutput("last", 32'(o_Last), 32'(exp_q[0].last));
      checkOutput("rerr", 32'(o_RangeErr), 32'(exp_q[0].rerr));
      if (rdy) void'(exp_q.pop_front());
    end
    if (v && exp_ready) modelPush(r);
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  function automatic logic [31:0] randImm();
    logic [31:0] edges [14];
    edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095,
              -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576, -32'sd1048576,
              32'h800, 32'h7FFFF800, 32'hFFFFF800};
    case ($urandom_range(0, 3))
      0: return 32'($signed($urandom_range(0, 10000)) - 5000);
      1: return $urandom;
      2: return $urandom & 32'hFFFFF000;
      default: return edges[$urandom_range(0, 13)];
    endcase
  endfunction

  function automatic req_t randReq();
    return mkReq(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), randImm());
  endfunction

  initial begin
    req_t idle, li_big;
    idle = '0;
`ifdef RANGE_CHECK_EN
    exp_range_2048 = 1'b1;
`else
    exp_range_2048 = 1'b0;
`endif
    i_rst = 1'b1; i_Valid = 1'b0; i_Ready = 1'b0;
    {i_Format, i_Opcode, i_Rd, i_Rs1, i_Rs2, i_Funct3, i_Funct7, i_Imm} = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_valid", 32'(o_Valid), 32'd0);
    checkOutput("rst_word", o_Instruction, 32'd0);
    checkOutput("rst_last", 32'(o_Last), 32'd0);
    checkOutput("rst_rerr", 32'(o_RangeErr), 32'd0);
    i_rst = 1'b0;
    #1 checkOutput("rst_ready", 32'(o_Ready), 32'd1);

    // ADDI x5,x6,-1
    applyStimulus(1'b1, mkReq(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF), 1'b1);
    checkOutput("tp_addi", o_Instruction, 32'hFFF30293);
    checkOutput("tp_addi_valid", 32'(o_Valid), 32'd1);

    // SW then BEQ back-to-back
    applyStimulus(1'b1, mkReq(3'd2, 7'h23, 5'd0, 5'd2, 5'd7, 3'd2, 7'd0, 32'd8), 1'b1);
    checkOutput("tp_sw", o_Instruction, 32'h00712423);
    applyStimulus(1'b1, mkReq(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16), 1'b1);
    checkOutput("tp_beq", o_Instruction, 32'h00208863);
    checkOutput("tp_beq_valid", 32'(o_Valid), 32'd1);
    applyStimulus(1'b0, idle, 1'b1);

    // LI x10,0x12345FFF with a 3-cycle stall
    li_big = mkReq(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    applyStimulus(1'b1, li_big, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("tp_lui", o_Instruction, 32'h12346537);
      checkOutput("tp_lui_last", 32'(o_Last), 32'd0);
      applyStimulus(1'b1, li_big, 1'b0);
    end
    checkOutput("tp_lui_hold", o_Instruction, 32'h12346537);
    applyStimulus(1'b0, idle, 1'b1);
    checkOutput("tp_li_addi", o_Instruction, 32'hFFF50513);
    checkOutput("tp_li_addi_last", 32'(o_Last), 32'd1);
    applyStimulus(1'b0, idle, 1'b1);

    // LI single-word cases
    applyStimulus(1'b1, mkReq(3'd6, 7'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 1'b1);
    checkOutput("tp_li5", o_Instruction, 32'h00500193);
    checkOutput("tp_li5_last", 32'(o_Last), 32'd1);
    applyStimulus(1'b1, mkReq(3'd6, 7'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1000), 1'b1);
    checkOutput("tp_li1000", o_Instruction, 32'h000011B7);
    checkOutput("tp_li1000_last", 32'(o_Last), 32'd1);

    // ADDI x1,x0,2048 range error
    applyStimulus(1'b1, mkReq(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), 1'b1);
    checkOutput("tp_range_word", o_Instruction, 32'h80000093);
    checkOutput("tp_range_flag", 32'(o_RangeErr), 32'(exp_range_2048));
    applyStimulus(1'b0, idle, 1'b1);

    // Reset while holding the LUI half of an LI
    applyStimulus(1'b1, li_big, 1'b0);
    i_rst = 1'b1; i_Valid = 1'b0; i_Ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    checkOutput("rst_li_valid", 32'(o_Valid), 32'd0);
    checkOutput("rst_li_word", o_Instruction, 32'd0);
    checkOutput("rst_li_ready", 32'(o_Ready), 32'd1);
    exp_q.delete();
    @(negedge i_clk);
    repeat (4) applyStimulus(1'b0, idle, 1'b1);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, randReq(), $urandom_range(0, 3) != 0);
    end
    repeat (4) applyStimulus(1'b0, idle, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder, the inverse of the immediate generator. It takes decoded fields and a full 32-bit immediate, and packs them into a 32-bit instruction word for R/I/S/B/U/J formats. It also expands the LI pseudo-op into a LUI+ADDI pair. It sits between the test-program/boot-ROM sequencer and the instruction memory write port, with valid/ready handshakes on both sides and a one-entry output register.

## Interface
- WORD_SIZE, 32, instruction and immediate width (fixed at 32; no other value supported)
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_Valid  input  1  request valid
- o_Ready  output  1  request accepted when i_Valid && o_Ready at clock edge
- i_Format  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI, 7=illegal
- i_Opcode  input  7  major opcode; ignored for LI
- i_Rd, i_Rs1, i_Rs2  input  5 each  register fields
- i_Funct3  input  3 ; i_Funct7  input  7
- i_Imm  input  32  full signed immediate (byte offset for B/J)
- o_Valid  output  1  o_Instruction valid
- i_Ready  input  1  downstream consumes word when o_Valid && i_Ready
- o_Instruction  output  32  encoded word
- o_Last  output  1  word is last of its request (always 1 except LUI half of 2-word LI)
- o_RangeErr  output  1  immediate not representable (see Configuration)

## Operation
- Packing (opcode always [6:0]):
  - R: {f7, rs2, rs1, f3, rd, op}
  - I: {imm[11:0], rs1, f3, rd, op}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Fields not used by a format are ignored.
- LI rd, imm:
  - lo12 = imm[11:0]; hi20 = (imm + 32'h800) >> 12, 32-bit wrap.
  - Word 1: LUI rd, hi20 (op 0110111).
  - Word 2: ADDI rd, rd, lo12 (op 0010011, f3 0).
  - If hi20 == 0: emit only ADDI rd, x0, lo12.
  - Else if lo12 == 0: emit only LUI.
- Illegal format (7): emit NOP 32'h00000013, o_Last=1.
- FSM:
  - EMPTY: o_Valid=0, o_Ready=1. On accept, load word and go to FULL, or to LI_HI if the request is a 2-word LI.
  - FULL: o_Valid=1, o_Ready=i_Ready. On consume with a new accept, load the new word (back-to-back). On consume without an accept, go to EMPTY.
  - LI_HI: o_Valid=1, holding LUI with o_Last=0, o_Ready=0. On consume, load ADDI with o_Last=1 and go to FULL.
- Output word and flags are stable while o_Valid && !i_Ready.

## Timing
- Reset values: state EMPTY, o_Valid=0, o_Instruction=0, o_Last=0, o_RangeErr=0. o_Ready=1 in the cycle after reset.
- Latency: accept at edge N, word visible with o_Valid=1 from edge N.
- Throughput: 1 word/cycle. A 2-word LI blocks input for exactly one extra consumed cycle.
- o_Ready is combinational from state and i_Ready. No combinational path from i_Valid to o_Valid.
- Reset asserted mid-LI (in LI_HI) discards the pending ADDI. Next state is EMPTY.
- Simultaneous consume and accept in FULL: the new word replaces the old one with no bubble.

## Configuration
- RANGE_CHECK_EN defined: o_RangeErr is registered alongside the word. It is set when:
  - I/S: imm is outside [-2048, 2047].
  - B: imm is outside [-4096, 4094] or imm[0] is set.
  - J: imm is outside [-2^20, 2^20-2] or imm[0] is set.
  - U: imm[11:0] != 0.
  - Format 7: always set.
  - R and LI: never set.
- The word is still emitted with truncated fields. For LI, the flag applies to both words (always 0).
- RANGE_CHECK_EN undefined: o_RangeErr is tied to 0 and there is no check logic.

## Test plan
- I: ADDI x5,x6,-1 (op 0x13, f3 0, imm 32'hFFFFFFFF) -> 32'hFFF30293, o_Last=1, o_RangeErr=0, one cycle after accept.
- S then B back-to-back with i_Ready=1:
  - SW x7,8(x2) (op 0x23, f3 2) -> 32'h00712423.
  - BEQ x1,x2,+16 (op 0x63) -> 32'h00208863 on the next cycle, no bubble.
- LI x10,32'h12345FFF with i_Ready held 0 for 3 cycles:
  - 32'h12346537 (o_Last=0) stays stable and o_Ready stays 0 while stalled.
  - Then 32'hFFF50513 (o_Last=1).
- LI edge cases:
  - LI x3,5 -> single word 32'h00500193.
  - LI x3,32'h00001000 -> single word 32'h000011B7.
- Range error: ADDI x1,x0,2048 -> word 32'h80000093. o_RangeErr=1 with RANGE_CHECK_EN, 0 without.
- Reset in LI_HI with i_Ready=0: next cycle o_Valid=0, o_Instruction=0, o_Ready=1, and no ADDI is ever emitted.
